// File: rtl/div_seq_pkg.sv
// -----------------------------------------------------------------------------
// div_seq_pkg
// Shared definitions for the sequential divider:
//   - div_state_t      : 2-bit FSM state encodings (IDLE, ZERO, BUSY, DONE)
//   - DIV_RESULT_BUS   : number of DATA_W words on the result bus ({rem, quo})
//   - div_result_bus_w : result bus width for a given operand width
// -----------------------------------------------------------------------------
package div_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ZERO = 2'b01,
        ST_BUSY = 2'b10,
        ST_DONE = 2'b11
    } div_state_t;

    // Result bus carries the remainder (HI word) and the quotient (LO word).
    localparam int DIV_RESULT_BUS = 2;

    function automatic int div_result_bus_w(input int data_w);
        return DIV_RESULT_BUS * data_w;
    endfunction

endpackage

// File: rtl/div_seq_sign_fix.sv
// -----------------------------------------------------------------------------
// div_sign_fix
// Sign conditioning for signed divides (used only when DIV_SIGNED_EN is set).
// Operand side : takes magnitudes of the operands and reports which results
//                must be negated (quotient if signs differ, remainder if the
//                dividend is negative).
// Result side  : applies the recorded negations to the unsigned core result.
// Ports:
//   signed_i                 1 = treat operands as two's complement
//   dividend_i, divisor_i    raw operands
//   dividend_abs_o,
//   divisor_abs_o            operand magnitudes (-2^(W-1) wraps to itself)
//   q_neg_o, r_neg_o         negate flags to be registered at acceptance
//   q_neg_i, r_neg_i         registered negate flags
//   quo_i, rem_i             unsigned core quotient / remainder
//   quo_o, rem_o             sign-corrected quotient / remainder
// -----------------------------------------------------------------------------
module div_sign_fix
    import div_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] dividend_abs_o,
    output logic [DATA_W-1:0] divisor_abs_o,
    output logic              q_neg_o,
    output logic              r_neg_o,
    input  logic              q_neg_i,
    input  logic              r_neg_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] rem_i,
    output logic [DATA_W-1:0] quo_o,
    output logic [DATA_W-1:0] rem_o
);

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1'b1);

    logic a_neg_s;
    logic b_neg_s;

    assign a_neg_s = signed_i & dividend_i[DATA_W-1];
    assign b_neg_s = signed_i & divisor_i[DATA_W-1];

    assign dividend_abs_o = a_neg_s ? (~dividend_i + ONE) : dividend_i;
    assign divisor_abs_o  = b_neg_s ? (~divisor_i + ONE) : divisor_i;
    assign q_neg_o        = a_neg_s ^ b_neg_s;
    assign r_neg_o        = a_neg_s;

    assign quo_o = q_neg_i ? (~quo_i + ONE) : quo_i;
    assign rem_o = r_neg_i ? (~rem_i + ONE) : rem_i;

endmodule

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
// Multi-cycle restoring divider for a pipeline EX stage.
// A divide is accepted from IDLE when start_i=1 and annul_i=0. A zero divisor
// short-cuts through ZERO (result 0, ready two cycles after acceptance);
// otherwise BUSY runs DATA_W shift-subtract steps and ready_o rises DATA_W+1
// cycles after acceptance. DONE holds the result while start_i stays high.
// Optional feature macro: DIV_SIGNED_EN -- enables signed (DIV) handling via
// div_sign_fix; without it signed_i is ignored and all divides are unsigned.
// Ports:
//   clk, rst (async, active low)
//   start_i, annul_i, signed_i, dividend_i, divisor_i   request side
//   result_o {remainder, quotient}, ready_o, stall_req_o response side
// -----------------------------------------------------------------------------
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start_i,
    input  logic                                annul_i,
    input  logic                                signed_i,
    input  logic [DATA_W-1:0]                   dividend_i,
    input  logic [DATA_W-1:0]                   divisor_i,
    output logic [div_result_bus_w(DATA_W)-1:0] result_o,
    output logic                                ready_o,
    output logic                                stall_req_o
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    div_state_t                          state_q;
    logic [CNT_W-1:0]                    cnt_q;
    logic [DATA_W-1:0]                   divisor_q;
    logic [DATA_W-1:0]                   quo_q;   // dividend shifts out, quotient shifts in
    logic [DATA_W-1:0]                   rem_q;
    logic [div_result_bus_w(DATA_W)-1:0] result_q;
    logic                                ready_q;

    logic [DATA_W:0]   partial_s;
    logic [DATA_W:0]   diff_s;
    logic [DATA_W-1:0] step_quo_s;
    logic [DATA_W-1:0] step_rem_s;
    logic [DATA_W-1:0] acc_dividend_s;
    logic [DATA_W-1:0] acc_divisor_s;
    logic [DATA_W-1:0] fix_quo_s;
    logic [DATA_W-1:0] fix_rem_s;

`ifdef DIV_SIGNED_EN
    logic acc_q_neg_s;
    logic acc_r_neg_s;
    logic q_neg_q;
    logic r_neg_q;

    div_sign_fix #(.DATA_W(DATA_W)) u_sign_fix (
        .signed_i       (signed_i),
        .dividend_i     (dividend_i),
        .divisor_i      (divisor_i),
        .dividend_abs_o (acc_dividend_s),
        .divisor_abs_o  (acc_divisor_s),
        .q_neg_o        (acc_q_neg_s),
        .r_neg_o        (acc_r_neg_s),
        .q_neg_i        (q_neg_q),
        .r_neg_i        (r_neg_q),
        .quo_i          (step_quo_s),
        .rem_i          (step_rem_s),
        .quo_o          (fix_quo_s),
        .rem_o          (fix_rem_s)
    );
`else
    logic unused_signed_s;
    assign unused_signed_s = signed_i;
    assign acc_dividend_s  = dividend_i;
    assign acc_divisor_s   = divisor_i;
    assign fix_quo_s       = step_quo_s;
    assign fix_rem_s       = step_rem_s;
`endif

    // One restoring step: shift next dividend bit into the partial remainder,
    // trial-subtract in DATA_W+1 bits, keep the difference only if non-negative.
    always_comb begin
        partial_s  = {rem_q, quo_q[DATA_W-1]};
        diff_s     = partial_s - {1'b0, divisor_q};
        step_quo_s = {quo_q[DATA_W-2:0], ~diff_s[DATA_W]};
        if (diff_s[DATA_W]) begin
            step_rem_s = partial_s[DATA_W-1:0];
        end else begin
            step_rem_s = diff_s[DATA_W-1:0];
        end
    end

    // Divider FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            ready_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    result_q <= '0;
                    ready_q  <= 1'b0;
                    if (start_i && !annul_i) begin
                        divisor_q <= acc_divisor_s;
                        quo_q     <= acc_dividend_s;
                        rem_q     <= '0;
                        cnt_q     <= '0;
`ifdef DIV_SIGNED_EN
                        q_neg_q   <= acc_q_neg_s;
                        r_neg_q   <= acc_r_neg_s;
`endif
                        state_q   <= (divisor_i == '0) ? ST_ZERO : ST_BUSY;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ZERO: begin
                    result_q <= '0;
                    if (annul_i) begin
                        ready_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_BUSY: begin
                    if (annul_i) begin
                        result_q <= '0;
                        ready_q  <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        quo_q <= step_quo_s;
                        rem_q <= step_rem_s;
                        cnt_q <= cnt_q + CNT_W'(1'b1);
                        if (cnt_q == LAST_STEP) begin
                            result_q <= {fix_rem_s, fix_quo_s};
                            ready_q  <= 1'b1;
                            state_q  <= ST_DONE;
                        end else begin
                            result_q <= '0;
                            ready_q  <= 1'b0;
                            state_q  <= ST_BUSY;
                        end
                    end
                end
                ST_DONE: begin
                    // Result is held only while the requester keeps start_i high.
                    if (annul_i || !start_i) begin
                        result_q <= '0;
                        ready_q  <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    result_q <= '0;
                    ready_q  <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign result_o    = result_q;
    assign ready_o     = ready_q;
    assign stall_req_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq
// Self-checking bench for div_seq: table of directed divides with
// hand-computed quotient/remainder/latency, plus sequences for DONE hold,
// annul mid-divide and reset mid-divide. Expected values for signed_i=1 rows
// depend on whether DIV_SIGNED_EN is defined.
// -----------------------------------------------------------------------------
module tb_div_seq;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        annul_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_req_o;

    int n_checks;
    int n_fail;

    typedef struct {
        string       nm;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    div_seq #(.DATA_W(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst_n),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .stall_req_o (stall_req_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Accept one divide, scramble inputs while busy, measure latency and result.
    task automatic run_vec(input vec_t v);
        int   n;
        logic seen;
        logic stall_ok;
        start_i    = 1'b1;
        signed_i   = v.sgn;
        dividend_i = v.a;
        divisor_i  = v.b;
        tick();                       // acceptance edge T
        dividend_i = $urandom;
        divisor_i  = $urandom;
        signed_i   = 1'($urandom_range(0, 1));
        chk($sformatf("%s_ready_after_accept", v.nm), {63'd0, ready_o}, 64'd0);
        n        = 0;
        seen     = 1'b0;
        stall_ok = 1'b1;
        while (!seen && n < 100) begin
            if (stall_req_o !== 1'b1) stall_ok = 1'b0;
            tick();
            n++;
            if (ready_o === 1'b1) seen = 1'b1;
        end
        // ready visible after edge T+lat-1, i.e. sampled high in cycle T+lat
        chk($sformatf("%s_latency", v.nm), 64'(n), 64'(v.lat - 1));
        chk($sformatf("%s_result", v.nm), result_o, {v.er, v.eq});
        chk($sformatf("%s_stall_at_done", v.nm), {63'd0, stall_req_o}, 64'd0);
        chk($sformatf("%s_stall_while_busy", v.nm), {63'd0, stall_ok}, 64'd1);
        start_i = 1'b0;
        tick();
        chk($sformatf("%s_idle_ready", v.nm), {63'd0, ready_o}, 64'd0);
        chk($sformatf("%s_idle_result", v.nm), result_o, 64'd0);
    endtask

    initial begin
        int   seen_cnt;
        logic [63:0] held;

        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{"u100_7",     1'b0, 32'd100,        32'd7,          32'h0000000E, 32'h00000002, 33};
        vecs[1]  = '{"div0",       1'b0, 32'h00001234,   32'h00000000,   32'h00000000, 32'h00000000, 2};
        vecs[2]  = '{"umax_1",     1'b0, 32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFF, 32'h00000000, 33};
        vecs[3]  = '{"u5_10",      1'b0, 32'd5,          32'd10,         32'h00000000, 32'h00000005, 33};
        vecs[4]  = '{"umax_umax",  1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 32'h00000000, 33};
        vecs[5]  = '{"umin_umax",  1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h00000000, 32'h80000000, 33};
        vecs[6]  = '{"uF9_2",      1'b0, 32'hFFFFFFF9,   32'h00000002,   32'h7FFFFFFC, 32'h00000001, 33};
        vecs[7]  = '{"s_div0",     1'b1, 32'd100,        32'h00000000,   32'h00000000, 32'h00000000, 2};
`ifdef DIV_SIGNED_EN
        vecs[8]  = '{"s_m7_2",     1'b1, 32'hFFFFFFF9,   32'h00000002,   32'hFFFFFFFD, 32'hFFFFFFFF, 33};
        vecs[9]  = '{"s_min_m1",   1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000, 33};
        vecs[10] = '{"s_7_m2",     1'b1, 32'h00000007,   32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001, 33};
`else
        vecs[8]  = '{"s_m7_2",     1'b1, 32'hFFFFFFF9,   32'h00000002,   32'h7FFFFFFC, 32'h00000001, 33};
        vecs[9]  = '{"s_min_m1",   1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h00000000, 32'h80000000, 33};
        vecs[10] = '{"s_7_m2",     1'b1, 32'h00000007,   32'hFFFFFFFE,   32'h00000000, 32'h00000007, 33};
`endif

        // Reset state
        rst_n      = 1'b0;
        start_i    = 1'b0;
        annul_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = 32'd0;
        divisor_i  = 32'd0;
        tick();
        tick();
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_result", result_o, 64'd0);
        chk("reset_stall", {63'd0, stall_req_o}, 64'd0);
        start_i = 1'b1;
        #1;
        chk("reset_stall_follows_start", {63'd0, stall_req_o}, 64'd1);
        start_i = 1'b0;
        rst_n   = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i]);
        end

        // DONE hold: result stays stable while start_i remains high
        start_i    = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd100;
        divisor_i  = 32'd7;
        tick();
        seen_cnt = 0;
        while (ready_o !== 1'b1 && seen_cnt < 100) begin
            tick();
            seen_cnt++;
        end
        chk("hold_latency", 64'(seen_cnt), 64'd32);
        held = result_o;
        dividend_i = 32'd9;
        divisor_i  = 32'd3;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("hold_ready_%0d", k), {63'd0, ready_o}, 64'd1);
            chk($sformatf("hold_result_%0d", k), result_o, 64'h00000002_0000000E);
        end
        start_i = 1'b0;
        tick();
        chk("hold_release_ready", {63'd0, ready_o}, 64'd0);

        // Annul at T+10: no ready ever, then next divide works normally
        start_i    = 1'b1;
        dividend_i = 32'd100;
        divisor_i  = 32'd7;
        tick();                          // edge T
        for (int k = 0; k < 9; k++) tick(); // after edge T+9
        annul_i = 1'b1;
        #1;
        chk("annul_stall", {63'd0, stall_req_o}, 64'd0);
        tick();                          // edge T+10 samples annul
        annul_i = 1'b0;
        start_i = 1'b0;
        seen_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (ready_o === 1'b1) seen_cnt++;
        end
        chk("annul_no_ready", 64'(seen_cnt), 64'd0);
        run_vec(vecs[0]);

        // Reset during BUSY: asserted after edge T+4, released after edge T+7
        start_i    = 1'b1;
        dividend_i = 32'd100;
        divisor_i  = 32'd7;
        tick();                          // edge T
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_mid_stall", {63'd0, stall_req_o}, 64'd1);
        for (int k = 0; k < 3; k++) tick();
        start_i = 1'b0;
        rst_n   = 1'b1;
        seen_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (ready_o === 1'b1 || result_o !== 64'd0) seen_cnt++;
        end
        chk("rst_no_ready", 64'(seen_cnt), 64'd0);
        run_vec(vecs[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width in bits.
REQ-002 SHALL have parameter CNT_W, default 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_i  in  1  EX stage requests a divide; held high until ready_o is seen.
REQ-006 SHALL have port annul_i  in  1  pipeline flush; aborts any in-flight divide.
REQ-007 SHALL have port signed_i  in  1  1 = DIV, 0 = DIVU; sampled at acceptance.
REQ-008 SHALL have port dividend_i  in  DATA_W  operand 1; sampled at acceptance.
REQ-009 SHALL have port divisor_i  in  DATA_W  operand 2; sampled at acceptance.
REQ-010 SHALL have port result_o  out  2*DATA_W  {remainder (HI), quotient (LO)}.
REQ-011 SHALL have port ready_o  out  1  result_o valid this cycle.
REQ-012 SHALL have port stall_req_o  out  1  stall request to the pipeline controller.

Function
REQ-013 SHALL implement a four-state FSM: IDLE, ZERO, BUSY, DONE.
REQ-014 IDLE: start_i=1 and annul_i=0 at edge T accepts the operands; divisor 0 -> ZERO, else BUSY with counter 0.
REQ-015 ZERO: SHALL last one cycle, then go to DONE with result_o = 0.
REQ-016 BUSY: SHALL perform one restoring shift-subtract step per cycle, DATA_W steps in total, then go to DONE.
REQ-017 Quotient bit: 1 when the partial remainder minus the divisor is non-negative, with a DATA_W+1-bit subtract; otherwise 0 and the remainder is restored.
REQ-018 Non-zero-divisor latency: ready_o SHALL be high in cycle T+DATA_W+1 (T+33 at default).
REQ-019 Zero-divisor latency: ready_o SHALL be high in cycle T+2.
REQ-020 DONE: ready_o=1 and result_o valid; if start_i=0, go to IDLE next cycle, else hold in DONE with result stable.
REQ-021 Outside DONE, ready_o SHALL be 0 and result_o SHALL be 0.
REQ-022 stall_req_o SHALL equal start_i AND NOT ready_o AND NOT annul_i (combinational).
REQ-023 annul_i=1 in ZERO, BUSY or DONE SHALL force IDLE next cycle, discard the result and suppress ready_o.
REQ-024 annul_i has priority over start_i in the same cycle.
REQ-025 Operands SHALL be registered at acceptance; input changes during BUSY SHALL have no effect.
REQ-026 A new start_i is accepted only from IDLE; no back-to-back acceptance from DONE without passing through IDLE.

Reset
REQ-027 While rst=0: state = IDLE, counter = 0, operand/remainder registers = 0, ready_o = 0, result_o = 0.
REQ-028 stall_req_o SHALL still follow REQ-022 during reset.
REQ-029 Reset asserted mid-divide SHALL abort immediately, with no ready pulse after release.

Configuration
REQ-030 Macro DIV_SIGNED_EN defined, signed_i=1: divide operand magnitudes, then negate the quotient if operand signs differ.
REQ-031 Macro DIV_SIGNED_EN defined: the remainder SHALL take the dividend's sign.
REQ-032 Macro DIV_SIGNED_EN defined: -2^(DATA_W-1) / -1 SHALL yield quotient 0x80000000 and remainder 0 (two's-complement wrap).
REQ-033 Macro DIV_SIGNED_EN undefined: signed_i SHALL be ignored, all divides unsigned, and no negation logic present.

Structure
REQ-034 The shared opcode/define package SHALL hold the FSM state encodings (2-bit) and the DIV_RESULT_BUS width define.
REQ-035 The FSM and datapath SHALL live in div_seq itself.
REQ-036 Sign conditioning (abs/negate) SHALL be one sub-module, div_sign_fix, instantiated only under DIV_SIGNED_EN.

Verification
REQ-037 Unsigned 100/7 accepted at T -> ready_o high at T+33, result_o = {0x00000002, 0x0000000E}, stall_req_o low at T+33.
REQ-038 Divisor 0, dividend 0x1234 -> ready_o at T+2, result_o = 0, no BUSY cycles.
REQ-039 DIV_SIGNED_EN, -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-040 DIV_SIGNED_EN, 0x80000000/0xFFFFFFFF signed -> quotient 0x80000000, remainder 0.
REQ-041 annul_i pulsed at T+10 -> IDLE at T+11, ready_o never asserted, next start_i accepted normally.
REQ-042 rst low at T+5 during BUSY, released at T+8 with start_i low -> outputs 0, state IDLE, no ready pulse.
